// File: rtl/el2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : el2_pkg
// Description : Shared types for the retirement trace path: the core's trace
//               packet, the trace-sink FIFO entry, header bit positions and
//               the trace-sink transmit state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package el2_pkg;

  // Retirement trace packet as driven by the core (104 bits).
  typedef struct packed {
    logic [31:0] trace_rv_i_insn_ip;
    logic [31:0] trace_rv_i_address_ip;
    logic        trace_rv_i_valid_ip;
    logic        trace_rv_i_exception_ip;
    logic [4:0]  trace_rv_i_ecause_ip;
    logic        trace_rv_i_interrupt_ip;
    logic [31:0] trace_rv_i_tval_ip;
  } el2_trace_pkt_t;

  // Stored FIFO entry: the packet without its valid bit, tagged with the
  // sequence number it was captured under and the drops that preceded it.
  typedef struct packed {
    logic [31:0] trace_rv_i_insn_ip;
    logic [31:0] trace_rv_i_address_ip;
    logic        trace_rv_i_exception_ip;
    logic [4:0]  trace_rv_i_ecause_ip;
    logic        trace_rv_i_interrupt_ip;
    logic [31:0] trace_rv_i_tval_ip;
    logic [15:0] seq;
    logic [7:0]  drop_cnt;
  } el2_trace_entry_t;

  // Header beat bit positions.
  localparam int TR_HDR_MARK_BIT   = 31;
  localparam int TR_HDR_EXC_BIT    = 30;
  localparam int TR_HDR_INT_BIT    = 29;
  localparam int TR_HDR_ECAUSE_MSB = 28;
  localparam int TR_HDR_ECAUSE_LSB = 24;
  localparam int TR_HDR_DROP_MSB   = 23;
  localparam int TR_HDR_DROP_LSB   = 16;
  localparam int TR_HDR_SEQ_MSB    = 15;
  localparam int TR_HDR_SEQ_LSB    = 0;

  typedef enum logic [2:0] {
    TX_IDLE = 3'd0,
    TX_HDR  = 3'd1,
    TX_ADDR = 3'd2,
    TX_INSN = 3'd3,
    TX_TVAL = 3'd4
  } el2_trace_tx_state_t;

  // Assemble the header beat of a stored packet.
  function automatic logic [31:0] trace_hdr(input logic       exc,
                                            input logic       intr,
                                            input logic [4:0] ecause,
                                            input logic [7:0] drop_cnt,
                                            input logic [15:0] seq);
    logic [31:0] h;
    h = '0;
    h[TR_HDR_MARK_BIT]                     = 1'b1;
    h[TR_HDR_EXC_BIT]                      = exc;
    h[TR_HDR_INT_BIT]                      = intr;
    h[TR_HDR_ECAUSE_MSB:TR_HDR_ECAUSE_LSB] = ecause;
    h[TR_HDR_DROP_MSB:TR_HDR_DROP_LSB]     = drop_cnt;
    h[TR_HDR_SEQ_MSB:TR_HDR_SEQ_LSB]       = seq;
    return h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/el2_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : el2_trace_fifo
// Description : Generic synchronous FIFO. Pointers carry one extra wrap bit so
//               full and empty are distinguished without a separate counter.
//               Push while full and pop while empty are ignored.
// Ports       : clk, rst (async, active-high)
//               push_i/din_i   - write request and data
//               pop_i/dout_o   - read request; dout_o shows the head entry
//               full_o/empty_o - occupancy flags
//               count_o        - number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module el2_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = push_i & ~full_o;
  assign w_do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (w_do_push) wptr_q <= wptr_q + 1'b1;
      if (w_do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

  assign dout_o  = mem_q[rptr_q[AW-1:0]];
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o = wptr_q - rptr_q;

endmodule
`default_nettype wire

// File: rtl/el2_trace_sink.sv
`default_nettype none
// ============================================================================
// Module      : el2_trace_sink
// Description : Captures retirement trace packets into a small FIFO and
//               serializes each as a 3-beat (plain) or 4-beat (trap) 32-bit
//               valid/ready stream. Never back-pressures the core: packets
//               arriving while the FIFO is full are dropped and counted.
// Ports       : clk, rst (async, active-high)
//               trace_pkt/trace_en      - core trace input and capture enable
//               tr_valid/tr_ready/tr_data/tr_last - outbound beat stream
//               ovf_clr/ovf_sticky      - drop indication and its clear
//               fifo_empty              - nothing stored, nothing in flight
// Revision    : 1.0 - initial release
// ============================================================================
module el2_trace_sink
  import el2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  el2_trace_pkt_t trace_pkt,
  input  logic           trace_en,
  output logic           tr_valid,
  input  logic           tr_ready,
  output logic [31:0]    tr_data,
  output logic           tr_last,
  input  logic           ovf_clr,
  output logic           ovf_sticky,
  output logic           fifo_empty
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = $bits(el2_trace_entry_t);

  logic                w_cap;
  logic                w_push;
  logic                w_drop;
  logic                w_pop;
  logic                w_last_hs;
  logic                w_trap;
  logic                w_ff_full;
  logic                w_ff_empty;
  logic [CW-1:0]       w_count;
  logic [EW-1:0]       w_head_raw;
  el2_trace_entry_t    w_entry;
  el2_trace_entry_t    w_head;
  logic                fifo_empty_d;

  logic [15:0]         seq_q;
  logic [7:0]          drop_cnt_q;
  logic                ovf_q;
  logic                fifo_empty_q;
  el2_trace_tx_state_t state_q;
  el2_trace_entry_t    cur_q;
  logic                tr_valid_q;
  logic [31:0]         tr_data_q;
  logic                tr_last_q;

  // Drop decision uses the registered count only: a pop in this cycle does
  // not make room for this cycle's packet.
  assign w_cap     = trace_en & trace_pkt.trace_rv_i_valid_ip;
  assign w_drop    = w_cap & (w_count == CW'(DEPTH));
  assign w_push    = w_cap & ~w_ff_full;
  assign w_pop     = (state_q == TX_HDR) & tr_ready;
  assign w_last_hs = tr_valid_q & tr_ready & tr_last_q;
  assign w_trap    = cur_q.trace_rv_i_exception_ip | cur_q.trace_rv_i_interrupt_ip;
  assign w_head    = el2_trace_entry_t'(w_head_raw);

  always_comb begin
    w_entry                         = '0;
    w_entry.trace_rv_i_insn_ip      = trace_pkt.trace_rv_i_insn_ip;
    w_entry.trace_rv_i_address_ip   = trace_pkt.trace_rv_i_address_ip;
    w_entry.trace_rv_i_exception_ip = trace_pkt.trace_rv_i_exception_ip;
    w_entry.trace_rv_i_ecause_ip    = trace_pkt.trace_rv_i_ecause_ip;
    w_entry.trace_rv_i_interrupt_ip = trace_pkt.trace_rv_i_interrupt_ip;
    w_entry.trace_rv_i_tval_ip      = trace_pkt.trace_rv_i_tval_ip;
    w_entry.seq                     = seq_q;
    w_entry.drop_cnt                = drop_cnt_q;
  end

  el2_trace_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .din_i   (w_entry),
    .pop_i   (w_pop),
    .dout_o  (w_head_raw),
    .full_o  (w_ff_full),
    .empty_o (w_ff_empty),
    .count_o (w_count)
  );

  // Capture counters and overflow flag; a drop outranks a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q      <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (w_cap) seq_q <= seq_q + 16'd1;
      if (w_push) begin
        drop_cnt_q <= '0;
      end else if (w_drop && drop_cnt_q != 8'hFF) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
      if (w_drop)       ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  // The FSM returns to IDLE only when the FIFO is empty, and a pop cannot
  // coincide with that, so the next stored count is zero exactly when no
  // push lands this cycle.
  assign fifo_empty_d = w_ff_empty & ~w_push & ((state_q == TX_IDLE) | w_last_hs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fifo_empty_q <= 1'b1;
    else     fifo_empty_q <= fifo_empty_d;
  end

  // Transmit FSM. The whole head entry is copied into cur_q when its header
  // is presented, so the FIFO slot can be released on header acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= TX_IDLE;
      cur_q      <= '0;
      tr_valid_q <= 1'b0;
      tr_data_q  <= '0;
      tr_last_q  <= 1'b0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (!w_ff_empty) begin
            state_q    <= TX_HDR;
            cur_q      <= w_head;
            tr_valid_q <= 1'b1;
            tr_data_q  <= trace_hdr(w_head.trace_rv_i_exception_ip, w_head.trace_rv_i_interrupt_ip,
                                    w_head.trace_rv_i_ecause_ip, w_head.drop_cnt, w_head.seq);
            tr_last_q  <= 1'b0;
          end
        end
        TX_HDR: begin
          if (tr_ready) begin
            state_q   <= TX_ADDR;
            tr_data_q <= cur_q.trace_rv_i_address_ip;
          end
        end
        TX_ADDR: begin
          if (tr_ready) begin
            state_q   <= TX_INSN;
            tr_data_q <= cur_q.trace_rv_i_insn_ip;
            tr_last_q <= ~w_trap;
          end
        end
        TX_INSN, TX_TVAL: begin
          if (tr_ready) begin
            if (state_q == TX_INSN && w_trap) begin
              state_q   <= TX_TVAL;
              tr_data_q <= cur_q.trace_rv_i_tval_ip;
              tr_last_q <= 1'b1;
            end else if (!w_ff_empty) begin
              state_q    <= TX_HDR;
              cur_q      <= w_head;
              tr_data_q  <= trace_hdr(w_head.trace_rv_i_exception_ip, w_head.trace_rv_i_interrupt_ip,
                                      w_head.trace_rv_i_ecause_ip, w_head.drop_cnt, w_head.seq);
              tr_last_q  <= 1'b0;
            end else begin
              state_q    <= TX_IDLE;
              tr_valid_q <= 1'b0;
              tr_data_q  <= '0;
              tr_last_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q    <= TX_IDLE;
          tr_valid_q <= 1'b0;
          tr_data_q  <= '0;
          tr_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tr_valid   = tr_valid_q;
  assign tr_data    = tr_data_q;
  assign tr_last    = tr_last_q;
  assign ovf_sticky = ovf_q;
  assign fifo_empty = fifo_empty_q;

endmodule
`default_nettype wire

// File: tb/tb_el2_trace_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_el2_trace_sink
// Description : Self-checking bench for el2_trace_sink. A packet-level
//               reference model (queue of expected beat lists plus capture
//               counters) is advanced once per clock alongside the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_el2_trace_sink;
  import el2_pkg::*;

  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  el2_trace_pkt_t pkt;
  logic           en;
  logic           rdy;
  logic           clr;
  logic           tr_valid;
  logic [31:0]    tr_data;
  logic           tr_last;
  logic           ovf_sticky;
  logic           fifo_empty;

  always #5 clk = ~clk;

  el2_trace_sink #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .trace_pkt  (pkt),
    .trace_en   (en),
    .tr_valid   (tr_valid),
    .tr_ready   (rdy),
    .tr_data    (tr_data),
    .tr_last    (tr_last),
    .ovf_clr    (clr),
    .ovf_sticky (ovf_sticky),
    .fifo_empty (fifo_empty)
  );

  // Expected packet: beats [31:0]=hdr, [63:32]=addr, [95:64]=insn, [127:96]=tval.
  typedef struct packed {
    logic [127:0] beats;
    logic [2:0]   n;
  } tpkt_t;

  tpkt_t       q[$];
  int          m_cnt;      // packets whose header has not been accepted yet
  int          bi;         // beat index within q[0]
  logic [15:0] m_seq;
  logic [7:0]  m_drop;
  logic        m_ovf;
  logic        prev_stall;
  logic [31:0] prev_data;
  logic        prev_last;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cnt = 0; bi = 0; m_seq = '0; m_drop = '0; m_ovf = 1'b0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
  endtask

  function automatic el2_trace_pkt_t mk(input logic [31:0] a, input logic [31:0] insn,
                                        input logic [31:0] tval, input logic exc,
                                        input logic intr, input logic [4:0] ec);
    el2_trace_pkt_t p;
    p = '0;
    p.trace_rv_i_valid_ip     = 1'b1;
    p.trace_rv_i_address_ip   = a;
    p.trace_rv_i_insn_ip      = insn;
    p.trace_rv_i_tval_ip      = tval;
    p.trace_rv_i_exception_ip = exc;
    p.trace_rv_i_interrupt_ip = intr;
    p.trace_rv_i_ecause_ip    = ec;
    return p;
  endfunction

  function automatic el2_trace_pkt_t mk_rand();
    return mk($urandom, $urandom, $urandom, $urandom_range(0, 3) == 0,
              $urandom_range(0, 5) == 0, 5'($urandom));
  endfunction

  // One clock: check the beat presented this cycle, update the model for
  // the coming edge, advance, then check registered status outputs.
  task automatic tick();
    int    cnt0;
    logic  drop;
    logic  trap;
    tpkt_t h;
    tpkt_t p;
    cnt0 = m_cnt;
    drop = 1'b0;
    if (prev_stall) begin
      chk("hold_valid", {31'b0, tr_valid}, 32'd1);
      chk("hold_data", tr_data, prev_data);
      chk("hold_last", {31'b0, tr_last}, {31'b0, prev_last});
    end
    if (tr_valid && rdy) begin
      if (q.size() == 0) begin
        chk("spurious_beat", {31'b0, tr_valid}, 32'd0);
      end else begin
        h = q[0];
        chk("beat_data", tr_data, h.beats[bi*32 +: 32]);
        chk("beat_last", {31'b0, tr_last}, {31'b0, (bi == int'(h.n) - 1)});
        if (bi == 0) m_cnt--;
        bi++;
        if (bi == int'(h.n)) begin
          void'(q.pop_front());
          bi = 0;
        end
      end
    end
    prev_stall = tr_valid && !rdy;
    prev_data  = tr_data;
    prev_last  = tr_last;
    if (en && pkt.trace_rv_i_valid_ip) begin
      if (cnt0 == DEPTH) begin
        drop   = 1'b1;
        m_drop = (m_drop == 8'hFF) ? 8'hFF : m_drop + 8'd1;
        m_ovf  = 1'b1;
      end else begin
        trap = pkt.trace_rv_i_exception_ip | pkt.trace_rv_i_interrupt_ip;
        p.beats = {pkt.trace_rv_i_tval_ip, pkt.trace_rv_i_insn_ip, pkt.trace_rv_i_address_ip,
                   1'b1, pkt.trace_rv_i_exception_ip, pkt.trace_rv_i_interrupt_ip,
                   pkt.trace_rv_i_ecause_ip, m_drop, m_seq};
        p.n = trap ? 3'd4 : 3'd3;
        q.push_back(p);
        m_cnt++;
        m_drop = '0;
      end
      m_seq = m_seq + 16'd1;
    end
    if (clr && !drop) m_ovf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ovf_sticky", {31'b0, ovf_sticky}, {31'b0, m_ovf});
    chk("fifo_empty", {31'b0, fifo_empty}, {31'b0, (q.size() == 0)});
    if (q.size() == 0) chk("idle_valid", {31'b0, tr_valid}, 32'd0);
  endtask

  task automatic drain();
    int k;
    en = 1'b0; pkt = '0; rdy = 1'b1; clr = 1'b0;
    k = 0;
    while (q.size() != 0 && k < 200) begin
      tick();
      k++;
    end
    chk("drain_done", q.size(), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0; pkt = '0; rdy = 1'b0; clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int nv, first, last, ncap, cyc;
    en = 1'b0; rdy = 1'b0; clr = 1'b0; pkt = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, tr_valid}, 32'd0);
    chk("rst_data", tr_data, 32'd0);
    chk("rst_last", {31'b0, tr_last}, 32'd0);
    chk("rst_ovf", {31'b0, ovf_sticky}, 32'd0);
    chk("rst_empty", {31'b0, fifo_empty}, 32'd1);
    rst = 1'b0;

    // Single plain packet, header latency N+2.
    rdy = 1'b1;
    pkt = mk(32'h8000_0010, 32'h0000_0013, 32'h0, 1'b0, 1'b0, 5'd0); en = 1'b1;
    tick();
    pkt = '0; en = 1'b0;
    chk("lat_n1_valid", {31'b0, tr_valid}, 32'd0);
    tick();
    chk("lat_n2_valid", {31'b0, tr_valid}, 32'd1);
    chk("lat_n2_hdr", tr_data, 32'h8000_0000);
    drain();

    // Trap packet (seq 1).
    pkt = mk(32'h0000_1000, 32'h0010_0073, 32'hDEAD_BEEF, 1'b1, 1'b0, 5'd2); en = 1'b1;
    tick();
    pkt = '0; en = 1'b0;
    tick();
    chk("trap_hdr", tr_data, 32'hC200_0001);
    drain();

    // Three back-to-back plain packets stream as 9 contiguous beats.
    nv = 0; first = -1; last = -1;
    for (int c = 0; c < 16; c++) begin
      if (c < 3) begin
        pkt = mk($urandom, $urandom, $urandom, 1'b0, 1'b0, 5'($urandom)); en = 1'b1;
      end else begin
        pkt = '0; en = 1'b0;
      end
      if (tr_valid) begin
        nv++;
        if (first < 0) first = c;
        last = c;
      end
      tick();
    end
    chk("b2b_beats", nv, 32'd9);
    chk("b2b_contig", last - first + 1, 32'd9);
    drain();

    // Overflow: 7 captures into a stalled 4-deep FIFO.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      pkt = mk_rand(); en = 1'b1;
      tick();
    end
    pkt = '0; en = 1'b0;
    chk("ovf_set", {31'b0, ovf_sticky}, 32'd1);
    drain();
    pkt = mk(32'h40, 32'h13, 32'h0, 1'b0, 1'b0, 5'd0); en = 1'b1;
    tick();
    pkt = '0; en = 1'b0;
    tick();
    chk("ovf_hdr", tr_data, 32'h8003_0007);
    drain();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovf_clr", {31'b0, ovf_sticky}, 32'd0);

    // Random back-pressure, 1000 captured packets.
    ncap = 0; cyc = 0;
    while (ncap < 1000 && cyc < 20000) begin
      rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 5) == 0) begin
        pkt = mk_rand();
        en  = ($urandom_range(0, 15) != 0);
        if (en) ncap++;
      end else begin
        pkt = '0;
        en  = ($urandom_range(0, 1) != 0);
      end
      tick();
      cyc++;
    end
    chk("rand_caps", ncap, 32'd1000);
    drain();

    // Sequence wrap and drop-count saturation.
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 65534; i++) begin
      pkt = mk_rand();
      clr = (i == 100);
      tick();
      if (i == 100) chk("ovf_set_wins", {31'b0, ovf_sticky}, 32'd1);
    end
    clr = 1'b0;
    drain();
    pkt = mk(32'h100, 32'h13, 32'h0, 1'b0, 1'b0, 5'd0); en = 1'b1;
    tick(); pkt = '0; en = 1'b0; tick();
    chk("wrap_hdr_fffe", tr_data, 32'h80FF_FFFE);
    drain();
    pkt = mk(32'h104, 32'h13, 32'h0, 1'b0, 1'b0, 5'd0); en = 1'b1;
    tick(); pkt = '0; en = 1'b0; tick();
    chk("wrap_hdr_ffff", tr_data, 32'h8000_FFFF);
    drain();
    pkt = mk(32'h108, 32'h13, 32'h0, 1'b0, 1'b0, 5'd0); en = 1'b1;
    tick(); pkt = '0; en = 1'b0; tick();
    chk("wrap_hdr_0000", tr_data, 32'h8000_0000);
    drain();

    // Reset asserted after the ADDR beat of a packet.
    rdy = 1'b1;
    pkt = mk(32'h200, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 5'd0); en = 1'b1;
    tick(); pkt = '0; en = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_insn", tr_data, 32'h1234_5678);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, tr_valid}, 32'd0);
    chk("mid_rst_data", tr_data, 32'd0);
    chk("mid_rst_last", {31'b0, tr_last}, 32'd0);
    chk("mid_rst_empty", {31'b0, fifo_empty}, 32'd1);
    chk("mid_rst_ovf", {31'b0, ovf_sticky}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    rdy = 1'b1;
    pkt = mk(32'h300, 32'h13, 32'h0, 1'b0, 1'b0, 5'd0); en = 1'b1;
    tick(); pkt = '0; en = 1'b0; tick();
    chk("post_rst_valid", {31'b0, tr_valid}, 32'd1);
    chk("post_rst_hdr", tr_data, 32'h8000_0000);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
